titan_wb_ram_responder: RTL
===========================

Name: titan_wb_ram_responder

Overview:
- Wishbone classic-cycle slave memory. Serves the core's instruction master port (read-only) and data master port (read/write) from one shared single-ported word array.
- Sits at the far end of the core's iwbm_*/dwbm_* buses. It is the reference target for simulation and the on-chip RAM for FPGA builds.
- Provides round-robin arbitration between the two ports, configurable wait states, byte-lane writes, and error responses for bad addresses.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- ADDR_WIDTH, 12, word-index bits; array holds 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles between request acceptance and response (0..15).
- MEM_INIT_FILE, "", hex file loaded with $readmemh at elaboration; empty string means contents are undefined.
- ROM_WORDS, 0, count of write-protected low words; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- iwbs_addr_i  in  32  instruction port byte address
- iwbs_cyc_i  in  1  instruction bus cycle
- iwbs_stb_i  in  1  instruction strobe
- iwbs_dat_o  out  32  instruction read data
- iwbs_ack_o  out  1  instruction ack
- iwbs_err_o  out  1  instruction error
- dwbs_addr_i  in  32  data port byte address
- dwbs_dat_i  in  32  data write data
- dwbs_sel_i  in  4  byte lane selects
- dwbs_we_i  in  1  write enable
- dwbs_cyc_i  in  1  data bus cycle
- dwbs_stb_i  in  1  data strobe
- dwbs_dat_o  out  32  data read data
- dwbs_ack_o  out  1  data ack
- dwbs_err_o  out  1  data error

Behaviour:
- Reset: single clock clk_i; rst_i is synchronous and active-high.
  - All ack/err outputs go to 0 and both dat_o go to 0.
  - FSM enters IDLE, wait counter clears, and last_served is set to INSTR.
  - Memory array contents are NOT reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE: a port requests when cyc&stb.
  - If only one port requests, that port is accepted.
  - If both request, the port opposite to last_served is accepted, then last_served is updated.
  - On acceptance, latch port id, address, we, sel and write data, and load counter = WAIT_STATES.
  - Go to RESP if the counter is 0, else WAIT.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
- RESP: performs the response on the clock edge that enters the ack cycle. The selected port's ack or err is high for exactly one cycle, then the FSM returns to IDLE.
- Latency: request accepted at cycle T gives ack/err high at cycle T+1+WAIT_STATES. The earliest next acceptance is T+2+WAIT_STATES.
- Abort: if the owning port's cyc_i drops while in WAIT or RESP-pending, return to IDLE with no ack/err, no write, and last_served still updated.
- Error conditions, reported as err instead of ack with the same latency:
  - address outside [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH);
  - addr[1:0] != 0.
  - On error: no write occurs and dat_o is held.
- Reads: the word at (addr-BASE_ADDR)>>2 is registered into the owning port's dat_o on the edge that raises ack. dat_o holds that value until the next read response on that port.
- Writes (data port only): byte lane i, bits 8i+7:8i, is written iff sel[i], on the edge that raises ack. sel=0 still acks and changes nothing. Writes do not update dwbs_dat_o.
- iwbs has no we; every instruction access is a read.
- ack and err are never high together. The non-owning port's ack/err stays 0.
- Reset mid-operation: the transaction is dropped, no ack is produced and memory is unchanged.

Optional Feature:
- Macro TITAN_WBRAM_ROM_PROTECT_EN.
- Defined: a data-port write to word index < ROM_WORDS responds err at normal latency and leaves memory unchanged. Reads and instruction fetches of those words are unaffected.
- Undefined: ROM_WORDS is ignored and all in-range aligned writes succeed.

Test Plan:
All scenarios use BASE_ADDR=0, ADDR_WIDTH=12, WAIT_STATES=1 unless noted.
1. Word write and read-back: data write 0xDEADBEEF to 0x100 with sel=4'hF, stb at T -> dwbs_ack_o high only at T+2. A read of 0x100 then returns dwbs_dat_o=0xDEADBEEF in its ack cycle.
2. Byte-lane write: write 0x0000AA00 to 0x100 with sel=4'b0010 -> a read of 0x100 returns 0xDEADAAEF. A write with sel=0 acks and the read-back is still 0xDEADAAEF.
3. Arbitration: after reset, both ports request 0x100 at T -> data port ack at T+2; instruction accepted at T+3 and acked at T+5 with iwbs_dat_o=0xDEADAAEF. The next simultaneous tie is won by the data port.
4. Address errors: read of 0x4000 -> dwbs_err_o at T+2, ack=0. Write of 0x11111111 to misaligned 0x102 -> err, and 0x100 still reads 0xDEADAAEF. Instruction fetch of 0xFFFF_FFFC -> iwbs_err_o.
5. Abort: with WAIT_STATES=3, data write 0x12345678 to 0x200, cyc dropped at T+1 -> no ack/err through T+6 and 0x200 is unchanged. A subsequent fetch of 0x200 is acked normally at acceptance+4.
6. Reset and write protect: assert rst_i at T+1 of a pending read -> ack/err/dat_o are 0 at T+2 and 0x100 still reads 0xDEADAAEF after reset. With the macro defined and ROM_WORDS=16, a write to 0x3C -> err with the word unchanged; a write to 0x40 -> ack.

Source files
------------

// File: rtl/titan_wb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : titan_wb_ram_responder
// Purpose  : Wishbone classic-cycle slave RAM shared by the core's
//            instruction master (read-only) and data master (read/write).
//            One single-ported word array serves both ports. A round-robin
//            arbiter picks the port, and a programmable wait-state counter
//            delays each response. Writes use byte lanes. Accesses that are
//            out of range or misaligned return err instead of ack.
// Ports    : clk_i, rst_i (synchronous, active-high)
//            iwbs_* : instruction port (addr/cyc/stb in; dat/ack/err out)
//            dwbs_* : data port (addr/dat/sel/we/cyc/stb in; dat/ack/err out)
// Options  : TITAN_WBRAM_ROM_PROTECT_EN - when defined, data-port writes to
//            word indices below ROM_WORDS return err and leave memory as-is.
// Revision : 1.0  initial release
// ============================================================================
module titan_wb_ram_responder #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          ADDR_WIDTH    = 12,
    parameter int          WAIT_STATES   = 1,
    parameter string       MEM_INIT_FILE = "",
    parameter int          ROM_WORDS     = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] iwbs_addr_i,
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic        dwbs_we_i,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o
);

    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_WAIT     = 4'(WAIT_STATES);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;
    localparam logic       c_PORT_I   = 1'b0;
`ifdef TITAN_WBRAM_ROM_PROTECT_EN
    localparam logic       c_ROM_EN   = 1'b1;
`else
    localparam logic       c_ROM_EN   = 1'b0;
`endif

    logic [31:0] r_mem [c_DEPTH];

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_last_served;
    logic        r_port;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;

    logic        w_ireq;
    logic        w_dreq;
    logic        w_accept;
    logic        w_grant_d;
    logic        w_idle;
    logic        w_owner_cyc;
    logic        w_fire;
    logic        w_tx_port;
    logic [31:0] w_tx_addr;
    logic        w_tx_we;
    logic [3:0]  w_tx_sel;
    logic [31:0] w_tx_wdata;
    logic [31:0] w_off;
    logic        w_in_range;
    logic        w_misalign;
    logic        w_rom_hit;
    logic        w_err;
    logic [ADDR_WIDTH-1:0] w_idx;

    // Arbitration: a lone requester wins; on a tie the port that was not
    // served last wins. last_served tracks every acceptance.
    assign w_ireq    = iwbs_cyc_i & iwbs_stb_i;
    assign w_dreq    = dwbs_cyc_i & dwbs_stb_i;
    assign w_accept  = w_ireq | w_dreq;
    assign w_grant_d = w_dreq & (~w_ireq | (r_last_served == c_PORT_I));
    assign w_idle    = (r_state == c_ST_IDLE);

    // With zero wait states the response fires on the accepting edge, so the
    // transaction fields come straight from the bus rather than the latches.
    assign w_tx_port  = w_idle ? w_grant_d : r_port;
    assign w_tx_addr  = w_idle ? (w_grant_d ? dwbs_addr_i : iwbs_addr_i) : r_addr;
    assign w_tx_we    = w_idle ? (w_grant_d & dwbs_we_i) : r_we;
    assign w_tx_sel   = w_idle ? dwbs_sel_i : r_sel;
    assign w_tx_wdata = w_idle ? dwbs_dat_i : r_wdata;

    assign w_owner_cyc = r_port ? dwbs_cyc_i : iwbs_cyc_i;

    // Offset wraps for addresses below BASE_ADDR, so a single upper-bits test
    // covers both ends of the window.
    assign w_off      = w_tx_addr - BASE_ADDR;
    assign w_in_range = ((w_off >> (ADDR_WIDTH + 2)) == 32'd0);
    assign w_idx      = w_off[ADDR_WIDTH+1:2];
    assign w_misalign = |w_tx_addr[1:0];
    assign w_rom_hit  = c_ROM_EN & w_tx_we &
                        ({{(32-ADDR_WIDTH){1'b0}}, w_idx} < 32'(ROM_WORDS));
    assign w_err      = ~w_in_range | w_misalign | w_rom_hit;

    // w_fire marks the edge that enters the ack/err cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (c_WAIT == 4'd0) begin
                        w_state_nxt = c_ST_RESP;
                        w_fire      = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                if (!w_owner_cyc) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ST_RESP;
                    w_fire      = 1'b1;
                end
            end
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= 4'd0;
            r_last_served <= c_PORT_I;
            r_port        <= c_PORT_I;
            r_addr        <= 32'd0;
            r_we          <= 1'b0;
            r_sel         <= 4'd0;
            r_wdata       <= 32'd0;
            iwbs_ack_o    <= 1'b0;
            iwbs_err_o    <= 1'b0;
            iwbs_dat_o    <= 32'd0;
            dwbs_ack_o    <= 1'b0;
            dwbs_err_o    <= 1'b0;
            dwbs_dat_o    <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            iwbs_ack_o <= 1'b0;
            iwbs_err_o <= 1'b0;
            dwbs_ack_o <= 1'b0;
            dwbs_err_o <= 1'b0;

            if (w_idle && w_accept) begin
                r_port        <= w_grant_d;
                r_last_served <= w_grant_d;
                r_addr        <= w_tx_addr;
                r_we          <= w_tx_we;
                r_sel         <= dwbs_sel_i;
                r_wdata       <= dwbs_dat_i;
                r_cnt         <= c_WAIT;
            end else if (r_state == c_ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_fire) begin
                if (w_err) begin
                    if (w_tx_port) dwbs_err_o <= 1'b1;
                    else           iwbs_err_o <= 1'b1;
                end else begin
                    if (w_tx_port) dwbs_ack_o <= 1'b1;
                    else           iwbs_ack_o <= 1'b1;
                    if (!w_tx_we) begin
                        if (w_tx_port) dwbs_dat_o <= r_mem[w_idx];
                        else           iwbs_dat_o <= r_mem[w_idx];
                    end
                end
            end
        end
    end

    // Storage is deliberately not reset; reset only suppresses a pending write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_fire && !w_err && w_tx_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_tx_sel[i]) r_mem[w_idx][8*i +: 8] <= w_tx_wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire
